// File: rtl/rx_frame_gate_if.sv
// Frame bus between the network/SPI receiver and the frame gate.
interface rx_frame_gate_if #(
    parameter int unsigned BUFFER_SIZE = 352
) ();

    logic                   sync;
    logic [BUFFER_SIZE-1:0] rx_data;
    logic [BUFFER_SIZE-1:0] frame_data;
    logic                   frame_valid;
    logic                   timeout;
    logic [15:0]            frame_count;
    logic [15:0]            error_count;

    // Receiver side: produces raw frames, consumes qualified results.
    modport master (
        output sync,
        output rx_data,
        input  frame_data,
        input  frame_valid,
        input  timeout,
        input  frame_count,
        input  error_count
    );

    // Gate side: consumes raw frames, produces qualified results.
    modport slave (
        input  sync,
        input  rx_data,
        output frame_data,
        output frame_valid,
        output timeout,
        output frame_count,
        output error_count
    );

endinterface

// File: rtl/rx_frame_gate.sv
// Qualifies received frames by header word, commits valid ones to a stable
// register and owns the link watchdog driving the design-wide timeout.
module rx_frame_gate #(
    parameter int unsigned BUFFER_SIZE = 352,
    parameter logic [31:0] HEADER      = 32'h74697277,
    parameter int unsigned TIMEOUT     = 2700000,
    parameter int unsigned MAX_BAD     = 3
) (
    input logic            clk,
    input logic            rst,
    rx_frame_gate_if.slave bus
);

    localparam int unsigned    WD_W    = $clog2(TIMEOUT + 1) + 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
    localparam logic [7:0]     BAD_MAX = 8'(MAX_BAD);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CHECK = 1'b1;

    logic [2:0]             s;
    logic                   sync_edge_c;
    logic [0:0]             state;
    logic [0:0]             next_state;
    logic [BUFFER_SIZE-1:0] stage;
    logic                   pending;
    logic [WD_W-1:0]        wd;
    logic [7:0]             bad_run;
    logic [31:0]            hdr_c;
    logic                   load_c;
    logic                   commit_c;
    logic                   reject_c;
    logic                   pend_set_c;
    logic [7:0]             bad_inc_c;
    logic                   bad_trip_c;

    // Header is the first four received bytes, reassembled little-endian.
    assign hdr_c = {stage[BUFFER_SIZE-25 -: 8], stage[BUFFER_SIZE-17 -: 8],
                    stage[BUFFER_SIZE-9 -: 8],  stage[BUFFER_SIZE-1 -: 8]};

    assign sync_edge_c = (s[2:1] == 2'b01);
    assign bad_inc_c   = (bad_run < BAD_MAX) ? bad_run + 8'd1 : bad_run;
    assign bad_trip_c  = reject_c && (bad_inc_c == BAD_MAX);

    // Bring the asynchronous frame strobe into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s <= 3'b000;
        else     s <= {s[1:0], bus.sync};
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state and control strobes.
    always_comb begin
        next_state = state;
        load_c     = 1'b0;
        commit_c   = 1'b0;
        reject_c   = 1'b0;
        pend_set_c = 1'b0;
        case (state)
            IDLE: begin
                if (sync_edge_c || pending) begin
                    load_c     = 1'b1;
                    next_state = CHECK;
                end
            end
            CHECK: begin
                if (hdr_c == HEADER) commit_c = 1'b1;
                else                 reject_c = 1'b1;
                pend_set_c = sync_edge_c;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Snapshot the raw frame and track at most one queued edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage   <= '0;
            pending <= 1'b0;
        end else begin
            if (load_c) stage <= bus.rx_data;
            if (load_c)          pending <= 1'b0;
            else if (pend_set_c) pending <= 1'b1;
        end
    end

    // Commit valid frames and maintain frame/error statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.frame_data  <= '0;
            bus.frame_valid <= 1'b0;
            bus.frame_count <= 16'd0;
            bus.error_count <= 16'd0;
            bad_run         <= 8'd0;
        end else begin
            bus.frame_valid <= commit_c;
            if (commit_c) begin
                bus.frame_data  <= stage;
                bus.frame_count <= bus.frame_count + 16'd1;
                bad_run         <= 8'd0;
            end else if (reject_c) begin
                if (bus.error_count != 16'hFFFF) bus.error_count <= bus.error_count + 16'd1;
                bad_run <= bad_inc_c;
            end
        end
    end

    // Link watchdog: a commit always wins over saturation or a bad-run trip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd          <= WD_MAX;
            bus.timeout <= 1'b1;
        end else if (commit_c) begin
            wd          <= '0;
            bus.timeout <= 1'b0;
        end else if (bad_trip_c) begin
            wd          <= WD_MAX;
            bus.timeout <= 1'b1;
        end else if (wd == WD_MAX) begin
            bus.timeout <= 1'b1;
        end else begin
            wd <= wd + WD_W'(1);
        end
    end

endmodule

// File: tb/tb_rx_frame_gate.sv
// Randomised self-checking bench for rx_frame_gate with a frame-level model.
module tb_rx_frame_gate;

    localparam int unsigned BS  = 352;
    localparam logic [31:0] HDR = 32'h74697277;
    localparam int unsigned TO  = 100;
    localparam int unsigned MB  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [BS-1:0] pulse_q[$];

    always #5 clk = ~clk;

    rx_frame_gate_if #(.BUFFER_SIZE(BS)) bus ();

    rx_frame_gate #(
        .BUFFER_SIZE(BS),
        .HEADER     (HDR),
        .TIMEOUT    (TO),
        .MAX_BAD    (MB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Record every frame_valid pulse together with the committed data.
    always begin
        @(posedge clk);
        #1;
        if (bus.frame_valid === 1'b1) pulse_q.push_back(bus.frame_data);
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1);
    end

    // Build a frame whose first four wire bytes carry hw little-endian.
    function automatic logic [BS-1:0] make_frame(input logic [31:0] hw, input bit rnd,
                                                 input logic [7:0] fill);
        logic [BS-1:0] f;
        for (int i = 0; i < BS / 8; i++) f[i*8 +: 8] = rnd ? 8'($urandom) : fill;
        f[BS-1 -: 8]  = hw[7:0];
        f[BS-9 -: 8]  = hw[15:8];
        f[BS-17 -: 8] = hw[23:16];
        f[BS-25 -: 8] = hw[31:24];
        return f;
    endfunction

    function automatic logic [31:0] bad_word();
        logic [31:0] w;
        w = $urandom;
        if (w == HDR) w = w ^ 32'h1;
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        bus.sync    = 1'b0;
        bus.rx_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        pulse_q.delete();
    endtask

    // Called at a negedge; returns at a negedge after hi high and lo low cycles.
    task automatic send_frame(input logic [BS-1:0] f, input int hi, input int lo);
        bus.rx_data = f;
        bus.sync    = 1'b1;
        repeat (hi) @(negedge clk);
        bus.sync = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic test_reset();
        int pulses;
        pulses = 0;
        rst = 1'b1;
        bus.sync = 1'b0;
        bus.rx_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.timeout !== 1'b1) begin
            errors++; $display("FAIL reset_timeout_held got %0b exp 1", bus.timeout);
        end
        rst = 1'b0;
        pulse_q.delete();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (bus.frame_valid !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL reset_no_valid got %0d exp 0", pulses); end
        checks++;
        if (bus.timeout !== 1'b1) begin errors++; $display("FAIL reset_timeout got %0b exp 1", bus.timeout); end
        checks++;
        if (bus.frame_data !== '0) begin errors++; $display("FAIL reset_frame_data got %0h exp 0", bus.frame_data); end
        checks++;
        if (bus.frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count got %0d exp 0", bus.frame_count); end
        checks++;
        if (bus.error_count !== 16'd0) begin errors++; $display("FAIL reset_error_count got %0d exp 0", bus.error_count); end
    endtask

    task automatic test_valid_frame();
        logic [BS-1:0] f;
        logic [3:0]    fv;
        do_reset();
        f = make_frame(HDR, 1'b0, 8'hA5);
        bus.rx_data = f;
        bus.sync    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            fv[i] = bus.frame_valid;
        end
        repeat (7) @(negedge clk);
        bus.sync = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (fv !== 4'b1000) begin errors++; $display("FAIL valid_latency got %b exp 1000", fv); end
        checks++;
        if (pulse_q.size() != 1) begin errors++; $display("FAIL valid_pulse_count got %0d exp 1", pulse_q.size()); end
        checks++;
        if (bus.frame_data !== f) begin errors++; $display("FAIL valid_frame_data got %0h exp %0h", bus.frame_data, f); end
        checks++;
        if (bus.frame_count !== 16'd1) begin errors++; $display("FAIL valid_frame_count got %0d exp 1", bus.frame_count); end
        checks++;
        if (bus.timeout !== 1'b0) begin errors++; $display("FAIL valid_timeout got %0b exp 0", bus.timeout); end
    endtask

    task automatic test_bad_header();
        logic [BS-1:0] good;
        logic          to_seen[3];
        do_reset();
        good = make_frame(HDR, 1'b1, 8'h00);
        send_frame(good, 3, 3);
        for (int i = 0; i < 3; i++) begin
            send_frame(make_frame(32'h0, 1'b0, 8'h3C), 3, 3);
            to_seen[i] = bus.timeout;
            if (i == 0) begin
                checks++;
                if (bus.error_count !== 16'd1) begin errors++; $display("FAIL bad_error_count got %0d exp 1", bus.error_count); end
                checks++;
                if (bus.frame_data !== good) begin errors++; $display("FAIL bad_keeps_data got %0h exp %0h", bus.frame_data, good); end
            end
        end
        checks++;
        if (to_seen[0] !== 1'b0 || to_seen[1] !== 1'b0) begin
            errors++; $display("FAIL bad_timeout_early got %b%b exp 00", to_seen[0], to_seen[1]);
        end
        checks++;
        if (to_seen[2] !== 1'b1) begin errors++; $display("FAIL bad_run_timeout got %0b exp 1", to_seen[2]); end
        checks++;
        if (pulse_q.size() != 1 || bus.frame_count !== 16'd1) begin
            errors++; $display("FAIL bad_no_commit got %0d pulses count %0d exp 1 1", pulse_q.size(), bus.frame_count);
        end
    endtask

    task automatic test_watchdog();
        bit   seen;
        logic t100, t101, t150, prev_to;
        do_reset();
        @(negedge clk);
        bus.rx_data = make_frame(HDR, 1'b1, 8'h00);
        bus.sync    = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = (bus.frame_valid === 1'b1);
        end
        bus.sync = 1'b0;
        checks++;
        if (!seen) begin errors++; $display("FAIL wd_first_commit got 0 exp 1"); end
        t100 = 1'bx; t101 = 1'bx; t150 = 1'bx;
        for (int i = 1; i <= 150; i++) begin
            @(posedge clk); #1;
            if (i == 100) t100 = bus.timeout;
            if (i == 101) t101 = bus.timeout;
            if (i == 150) t150 = bus.timeout;
        end
        checks++;
        if (t100 !== 1'b0) begin errors++; $display("FAIL wd_before got %0b exp 0", t100); end
        checks++;
        if (t101 !== 1'b1) begin errors++; $display("FAIL wd_rise got %0b exp 1", t101); end
        checks++;
        if (t150 !== 1'b1) begin errors++; $display("FAIL wd_stays got %0b exp 1", t150); end
        @(negedge clk);
        bus.rx_data = make_frame(HDR, 1'b1, 8'h00);
        bus.sync    = 1'b1;
        prev_to = bus.timeout;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.frame_valid === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (bus.timeout !== 1'b0 || prev_to !== 1'b1) begin
                    errors++; $display("FAIL wd_clear got %0b prev %0b exp 0 prev 1", bus.timeout, prev_to);
                end
            end
            prev_to = bus.timeout;
        end
        bus.sync = 1'b0;
        if (!seen) begin checks++; errors++; $display("FAIL wd_second_commit got 0 exp 1"); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [BS-1:0] exp_q[$];
        logic [BS-1:0] f;
        logic [BS-1:0] got;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            f = make_frame(HDR, 1'b1, 8'h00);
            exp_q.push_back(f);
            send_frame(f, 2, 2);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (pulse_q.size() != 8) begin errors++; $display("FAIL b2b_pulses got %0d exp 8", pulse_q.size()); end
        checks++;
        if (bus.frame_count !== 16'd8) begin errors++; $display("FAIL b2b_frame_count got %0d exp 8", bus.frame_count); end
        for (int i = 0; i < 8 && pulse_q.size() > 0; i++) begin
            got = pulse_q.pop_front();
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL b2b_data_%0d got %0h exp %0h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_reset_during_check();
        do_reset();
        bus.rx_data = make_frame(HDR, 1'b1, 8'h00);
        bus.sync    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b1;
        bus.sync = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (pulse_q.size() != 0) begin errors++; $display("FAIL rstchk_pulses got %0d exp 0", pulse_q.size()); end
        checks++;
        if (bus.frame_count !== 16'd0) begin errors++; $display("FAIL rstchk_frame_count got %0d exp 0", bus.frame_count); end
        checks++;
        if (bus.timeout !== 1'b1) begin errors++; $display("FAIL rstchk_timeout got %0b exp 1", bus.timeout); end
        checks++;
        if (bus.frame_data !== '0) begin errors++; $display("FAIL rstchk_frame_data got %0h exp 0", bus.frame_data); end
    endtask

    // Random mix of good and bad frames against a frame-level model.
    task automatic test_random();
        logic [BS-1:0] f;
        logic [BS-1:0] m_data;
        logic [BS-1:0] got;
        int            m_frames, m_errors, m_run;
        logic          m_to;
        bit            good;
        do_reset();
        m_data = '0; m_frames = 0; m_errors = 0; m_run = 0; m_to = 1'b1;
        for (int n = 0; n < 30; n++) begin
            good = ($urandom_range(0, 1) == 1);
            f = make_frame(good ? HDR : bad_word(), 1'b1, 8'h00);
            send_frame(f, int'($urandom_range(2, 6)), int'($urandom_range(2, 6)));
            if (good) begin
                m_data = f; m_frames++; m_run = 0; m_to = 1'b0;
            end else begin
                m_errors++;
                if (m_run < int'(MB)) m_run++;
                if (m_run == int'(MB)) m_to = 1'b1;
            end
            checks++;
            if (pulse_q.size() != (good ? 1 : 0)) begin
                errors++; $display("FAIL rnd_pulses_%0d got %0d exp %0d", n, pulse_q.size(), good ? 1 : 0);
            end
            if (pulse_q.size() > 0) begin
                got = pulse_q.pop_front();
                pulse_q.delete();
                checks++;
                if (got !== m_data) begin errors++; $display("FAIL rnd_data_%0d got %0h exp %0h", n, got, m_data); end
            end
            checks++;
            if (bus.frame_count !== 16'(m_frames)) begin
                errors++; $display("FAIL rnd_frame_count_%0d got %0d exp %0d", n, bus.frame_count, m_frames);
            end
            checks++;
            if (bus.error_count !== 16'(m_errors)) begin
                errors++; $display("FAIL rnd_error_count_%0d got %0d exp %0d", n, bus.error_count, m_errors);
            end
            checks++;
            if (bus.timeout !== m_to) begin
                errors++; $display("FAIL rnd_timeout_%0d got %0b exp %0b", n, bus.timeout, m_to);
            end
        end
    endtask

    initial begin
        bus.sync    = 1'b0;
        bus.rx_data = '0;
        test_reset();
        test_valid_frame();
        test_bad_header();
        test_watchdog();
        test_back_to_back();
        test_reset_during_check();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
